// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Purpose:
//    Conditions a raw, asynchronous, active-high push button. The input is
//    synchronized through two flops and then debounced: a new level is
//    accepted only after it has been seen continuously for DEBOUNCE_CYCLES
//    cycles. Single-cycle press/release pulses mark accepted edges. An
//    optional auto-repeat engine emits repeat pulses while the button is held.
//
// Configuration:
//    BUTTON_CONDITIONER_REPEAT_EN - when defined, the hold/repeat FSM and its
//    counters are built. When undefined, repeat_o is tied low and the port
//    list is unchanged.
//
// Parameters:
//    DEBOUNCE_CYCLES - stable cycles needed to accept a new level (2..2^24)
//    REPEAT_DELAY    - cycles from accepted press to first repeat (2..2^28)
//    REPEAT_PERIOD   - cycles between later repeat pulses (2..2^28)
//
// Ports:
//    clk         in   system clock, rising-edge active
//    rst_n       in   asynchronous active-low reset
//    btn_i       in   raw button, asynchronous to clk, active-high
//    btn_level_o out  debounced button level
//    press_o     out  one-cycle pulse on accepted press
//    release_o   out  one-cycle pulse on accepted release
//    repeat_o    out  one-cycle auto-repeat pulse while held
// -----------------------------------------------------------------------------
module button_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 32'd1000000,
   parameter int unsigned REPEAT_DELAY    = 32'd50000000,
   parameter int unsigned REPEAT_PERIOD   = 32'd10000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic btn_level_o,
   output logic press_o,
   output logic release_o,
   output logic repeat_o
);

   localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 32'd1);
   localparam logic [DB_W-1:0] DB_ONE  = DB_W'(32'd1);

   logic [1:0]      sync_r;
   logic            btn_s;
   logic            level_r;
   logic            press_r;
   logic            release_r;
   logic [DB_W-1:0] db_cnt_r;
   logic            differ_s;
   logic            db_done_s;
   logic            accept_press_s;
   logic            accept_release_s;

   // Two-flop synchronizer for the asynchronous button input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= 2'b00;
      end else begin
         sync_r <= {sync_r[0], btn_i};
      end
   end

   assign btn_s = sync_r[1];

   // Debounce decode: a level is accepted on the edge where the mismatch
   // has already lasted DEBOUNCE_CYCLES-1 cycles and is still present.
   always_comb begin
      differ_s         = btn_s ^ level_r;
      db_done_s        = differ_s & (db_cnt_r == DB_LAST);
      accept_press_s   = db_done_s & btn_s;
      accept_release_s = db_done_s & ~btn_s;
   end

   // Debounce counter: counts consecutive mismatch cycles, cleared on any
   // agreement and on acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_cnt_r <= '0;
      end else if (!differ_s || db_done_s) begin
         db_cnt_r <= '0;
      end else begin
         db_cnt_r <= db_cnt_r + DB_ONE;
      end
   end

   // Debounced level plus registered press/release pulses; the pulses are
   // loaded on the same edge as the level so they mark its first cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_r   <= 1'b0;
         press_r   <= 1'b0;
         release_r <= 1'b0;
      end else begin
         if (db_done_s) begin
            level_r <= btn_s;
         end else begin
            level_r <= level_r;
         end
         press_r   <= accept_press_s;
         release_r <= accept_release_s;
      end
   end

   assign btn_level_o = level_r;
   assign press_o     = press_r;
   assign release_o   = release_r;

`ifdef BUTTON_CONDITIONER_REPEAT_EN

   localparam int unsigned       HOLD_W    = $clog2(REPEAT_DELAY);
   localparam int unsigned       REP_W     = $clog2(REPEAT_PERIOD);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(REPEAT_DELAY - 32'd1);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(32'd1);
   localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_PERIOD - 32'd1);
   localparam logic [REP_W-1:0]  REP_ONE   = REP_W'(32'd1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_HOLD   = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;

   logic [1:0]        state_r;
   logic [1:0]        state_nx_s;
   logic [HOLD_W-1:0] hold_cnt_r;
   logic [HOLD_W-1:0] hold_cnt_nx_s;
   logic [REP_W-1:0]  rep_cnt_r;
   logic [REP_W-1:0]  rep_cnt_nx_s;
   logic              repeat_r;
   logic              repeat_nx_s;

   // Repeat FSM next-state logic. An accepted release is tested first so it
   // overrides a repeat expiring on the same edge.
   always_comb begin
      state_nx_s    = state_r;
      hold_cnt_nx_s = hold_cnt_r;
      rep_cnt_nx_s  = rep_cnt_r;
      repeat_nx_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            hold_cnt_nx_s = '0;
            rep_cnt_nx_s  = '0;
            if (accept_press_s) begin
               state_nx_s = ST_HOLD;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (accept_release_s) begin
               state_nx_s    = ST_IDLE;
               hold_cnt_nx_s = '0;
            end else if (hold_cnt_r == HOLD_LAST) begin
               state_nx_s    = ST_REPEAT;
               hold_cnt_nx_s = '0;
               rep_cnt_nx_s  = '0;
               repeat_nx_s   = 1'b1;
            end else begin
               hold_cnt_nx_s = hold_cnt_r + HOLD_ONE;
            end
         end
         ST_REPEAT: begin
            if (accept_release_s) begin
               state_nx_s   = ST_IDLE;
               rep_cnt_nx_s = '0;
            end else if (rep_cnt_r == REP_LAST) begin
               rep_cnt_nx_s = '0;
               repeat_nx_s  = 1'b1;
            end else begin
               rep_cnt_nx_s = rep_cnt_r + REP_ONE;
            end
         end
         default: begin
            state_nx_s    = ST_IDLE;
            hold_cnt_nx_s = '0;
            rep_cnt_nx_s  = '0;
         end
      endcase
   end

   // Repeat FSM state, counters and registered repeat pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         hold_cnt_r <= '0;
         rep_cnt_r  <= '0;
         repeat_r   <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         hold_cnt_r <= hold_cnt_nx_s;
         rep_cnt_r  <= rep_cnt_nx_s;
         repeat_r   <= repeat_nx_s;
      end
   end

   assign repeat_o = repeat_r;

`else

   assign repeat_o = 1'b0;

`endif

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=5. Expected values are hand-derived: a btn_i
// change made just after edge E shows on btn_level_o at edge E+6.
// Repeat expectations follow BUTTON_CONDITIONER_REPEAT_EN.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

   localparam int unsigned DB = 32'd4;
   localparam int unsigned RD = 32'd10;
   localparam int unsigned RP = 32'd5;

`ifdef BUTTON_CONDITIONER_REPEAT_EN
   localparam bit REP_EN = 1'b1;
   localparam int HOLD_N = 29;
`else
   localparam bit REP_EN = 1'b0;
   localparam int HOLD_N = 100;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic btn_i;
   logic btn_level_o;
   logic press_o;
   logic release_o;
   logic repeat_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       rst_n;
      logic       btn;
      logic [3:0] exp;   // {level, press, release, repeat}
   } vec_t;

   vec_t vecs[$];

   button_conditioner #(
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_i       (btn_i),
      .btn_level_o (btn_level_o),
      .press_o     (press_o),
      .release_o   (release_o),
      .repeat_o    (repeat_o)
   );

   always #5 clk = ~clk;

   function automatic void add(int n, logic r, logic b, logic [3:0] e);
      vec_t v;
      v.rst_n = r;
      v.btn   = b;
      v.exp   = e;
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endfunction

   function automatic logic [3:0] outs();
      return {btn_level_o, press_o, release_o, repeat_o};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got {lvl,prs,rel,rep}=%b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Waits (bounded) for press_o and checks it arrives exactly 6 edges on.
   task automatic wait_press(input string name);
      int n;
      n = 0;
      while (!press_o && n < 20) begin
         tick();
         n++;
      end
      chk_int({name, "_latency"}, n, 6);
      chk({name, "_press"}, outs(), 4'b1100);
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      btn_i = 1'b0;
      tick();
      tick();
      chk("reset_state", outs(), 4'b0000);
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      logic exp_rep;
      rst_n = 1'b0;
      btn_i = 1'b0;

      // Table: press, release, 3-cycle glitch, exact 4-cycle pulse.
      add(1, 1'b0, 1'b0, 4'b0000);
      add(1, 1'b1, 1'b0, 4'b0000);
      add(5, 1'b1, 1'b1, 4'b0000);
      add(1, 1'b1, 1'b1, 4'b1100);
      add(2, 1'b1, 1'b1, 4'b1000);
      add(5, 1'b1, 1'b0, 4'b1000);
      add(1, 1'b1, 1'b0, 4'b0010);
      add(1, 1'b1, 1'b0, 4'b0000);
      add(3, 1'b1, 1'b1, 4'b0000);
      add(8, 1'b1, 1'b0, 4'b0000);
      add(4, 1'b1, 1'b1, 4'b0000);
      add(1, 1'b1, 1'b0, 4'b0000);
      add(1, 1'b1, 1'b0, 4'b1100);
      add(3, 1'b1, 1'b0, 4'b1000);
      add(1, 1'b1, 1'b0, 4'b0010);
      add(1, 1'b1, 1'b0, 4'b0000);

      foreach (vecs[i]) begin
         rst_n = vecs[i].rst_n;
         btn_i = vecs[i].btn;
         tick();
         chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
      end

      // Long hold: repeat pulses at 10,15,20,25 after press (or none).
      reset_dut();
      btn_i = 1'b1;
      wait_press("hold");
      for (int k = 1; k <= HOLD_N; k++) begin
         tick();
         exp_rep = REP_EN && (k >= 10) && (((k - 10) % 5) == 0);
         chk($sformatf("hold_k%0d", k), outs(), {1'b1, 1'b0, 1'b0, exp_rep});
      end

      // Release accepted on the edge the repeat counter expires.
      reset_dut();
      btn_i = 1'b1;
      wait_press("rwin");
      for (int k = 1; k <= 9; k++) begin
         tick();
         chk($sformatf("rwin_k%0d", k), outs(), 4'b1000);
      end
      btn_i = 1'b0;
      for (int k = 10; k <= 14; k++) begin
         tick();
         exp_rep = REP_EN && (k == 10);
         chk($sformatf("rwin_k%0d", k), outs(), {1'b1, 1'b0, 1'b0, exp_rep});
      end
      tick();
      chk("rwin_release", outs(), 4'b0010);
      for (int k = 16; k <= 25; k++) begin
         tick();
         chk($sformatf("rwin_idle_k%0d", k), outs(), 4'b0000);
      end

      // Reset pulsed 2 cycles after press with button held.
      reset_dut();
      btn_i = 1'b1;
      wait_press("rst1");
      tick();
      tick();
      chk("rst_pre", outs(), 4'b1000);
      rst_n = 1'b0;
      #1;
      chk("rst_async", outs(), 4'b0000);
      tick();
      chk("rst_low1", outs(), 4'b0000);
      tick();
      chk("rst_low2", outs(), 4'b0000);
      rst_n = 1'b1;
      wait_press("rst2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, 1000000, consecutive synchronized-mismatch cycles required to accept a new button level (legal range 2..2^24).
REQ-002 Parameter REPEAT_DELAY, 50000000, cycles from accepted press to first repeat pulse (legal range 2..2^28).
REQ-003 Parameter REPEAT_PERIOD, 10000000, cycles between subsequent repeat pulses (legal range 2..2^28).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL be clocked on the rising edge of clk.
REQ-005 Port clk  input  1  system clock (100 MHz PLL output).
REQ-006 Port rst_n  input  1  asynchronous active-low reset.
REQ-007 Port btn_i  input  1  raw breadboard button, asynchronous to clk, active-high.
REQ-008 Port btn_level_o  output  1  debounced button level.
REQ-009 Port press_o  output  1  single-cycle pulse on accepted press.
REQ-010 Port release_o  output  1  single-cycle pulse on accepted release.
REQ-011 Port repeat_o  output  1  single-cycle auto-repeat pulse while held.

Function
REQ-012 btn_i SHALL pass through a 2-flop synchronizer; only the second flop output (btn_s) SHALL be used downstream.
REQ-013 The debounce counter SHALL increment each cycle btn_s differs from btn_level_o and SHALL clear to 0 on any cycle they are equal.
REQ-014 On the edge where the counter equals DEBOUNCE_CYCLES-1 and btn_s still differs, btn_level_o SHALL take btn_s and the counter SHALL clear.
REQ-015 Latency: a clean btn_i edge SHALL appear on btn_level_o exactly 2+DEBOUNCE_CYCLES clock edges later.
REQ-016 Any btn_s pulse or glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no change on any output.
REQ-017 press_o SHALL be high for exactly the first cycle btn_level_o is 1; release_o for exactly the first cycle btn_level_o is 0 after being 1; both are registered outputs.
REQ-018 press_o and release_o SHALL never be high in the same cycle.
REQ-019 Repeat FSM states: IDLE (btn_level_o=0), HOLD (waiting REPEAT_DELAY), REPEAT (waiting REPEAT_PERIOD).
REQ-020 IDLE->HOLD on accepted press, hold counter cleared; HOLD->REPEAT when hold counter reaches REPEAT_DELAY-1, asserting repeat_o for that one cycle; REPEAT asserts repeat_o every REPEAT_PERIOD cycles thereafter.
REQ-021 Accepted release in HOLD or REPEAT SHALL return to IDLE with repeat_o low in that cycle, even if the repeat counter expires on the same edge (release wins).
REQ-022 Hold/repeat counters SHALL saturate-free wrap only by explicit clear; widths SHALL be clog2 of their parameter.

Reset
REQ-023 While rst_n=0: synchronizer flops, btn_level_o, press_o, release_o, repeat_o = 0; all counters = 0; FSM = IDLE.
REQ-024 Reset asserted mid-debounce or mid-hold SHALL discard all progress; after deassertion a held button SHALL be re-accepted after 2+DEBOUNCE_CYCLES cycles with a fresh press_o.

Configuration
REQ-025 Macro BUTTON_CONDITIONER_REPEAT_EN: when defined, the repeat FSM and counters (REQ-019..REQ-022) SHALL be compiled in.
REQ-026 When BUTTON_CONDITIONER_REPEAT_EN is undefined, repeat logic SHALL be absent, repeat_o SHALL be tied to 0, and the port list SHALL be unchanged.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-027 btn_i 0->1 held -> btn_level_o=1 and press_o one-cycle pulse exactly 6 edges after the input change; release_o stays 0.
REQ-028 btn_i high 3 cycles then low (glitch) -> btn_level_o, press_o, release_o, repeat_o stay 0 throughout.
REQ-029 Macro defined, button held 30 cycles after press_o -> repeat_o pulses at 10, 15, 20, 25 cycles after press_o, nothing else.
REQ-030 Macro defined, release accepted on the same edge the repeat counter expires -> release_o=1, repeat_o=0, FSM=IDLE.
REQ-031 rst_n pulsed low 2 cycles after press_o with button still held -> all outputs 0 during reset; press_o reasserted 6 cycles after rst_n rises.
REQ-032 Macro undefined, button held 100 cycles -> repeat_o constant 0; press/release behaviour identical to REQ-027.
